// File: rtl/axis_test_gen.sv
// -----------------------------------------------------------------------------
// axis_test_gen
//
// AXI-Stream test-pattern source for the 128-bit link datapath. A start pulse
// launches a run of fixed-length packets separated by a programmable idle gap.
// Every beat describes itself, so a sink can check it without side information:
//   tdata[127:96] packet index (pkt_cnt at packet start, zero-extended)
//   tdata[ 95:64] beat index within the packet (zero-extended)
//   tdata[ 63: 0] payload word (incrementing counter, or a PRBS when enabled)
//   tlast         set on beat index == effective pkt_len - 1
//
// Build option:
//   AXIS_TEST_GEN_PRBS_EN  when defined, the payload is a 64-bit Fibonacci LFSR
//                          (taps 63,62,60,59; seed 64'h1). When undefined, the
//                          payload is a counter starting at 0 and no LFSR
//                          logic exists.
//
// Ports:
//   i_link_clk            stream clock, all logic on the rising edge
//   i_rst                 asynchronous active-high reset
//   i_start               one-cycle pulse: latch config and begin a run
//   i_stop                one-cycle pulse: finish current packet, end the run
//   i_pkt_len             beats per packet (0 behaves as 1)
//   i_gap_len             idle cycles between packets
//   i_pkt_num             packets per run (0 = until stop)
//   o_m_axis_link_tdata   beat data
//   o_m_axis_link_tlast   last beat of packet
//   o_m_axis_link_tvalid  beat valid
//   i_m_axis_link_tready  sink ready
//   o_busy                run in progress
//   o_done                one-cycle pulse when a run ends
//   o_pkt_cnt             packets completed in the current/last run
// -----------------------------------------------------------------------------
module axis_test_gen #(
    parameter int PKT_LEN_W = 16
) (
    input  logic                 i_link_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [PKT_LEN_W-1:0] i_pkt_len,
    input  logic [7:0]           i_gap_len,
    input  logic [15:0]          i_pkt_num,
    output logic [127:0]         o_m_axis_link_tdata,
    output logic                 o_m_axis_link_tlast,
    output logic                 o_m_axis_link_tvalid,
    input  logic                 i_m_axis_link_tready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [15:0]          o_pkt_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    // -------------------------------------------------------------------------
    // Registers and their next-state values
    // -------------------------------------------------------------------------
    state_t                 r_state,     w_state_next;
    logic [PKT_LEN_W-1:0]   r_last_idx,  w_last_idx_next;   // effective pkt_len - 1
    logic [7:0]             r_gap_len,   w_gap_len_next;
    logic [15:0]            r_pkt_num,   w_pkt_num_next;
    logic [15:0]            r_pkt_cnt,   w_pkt_cnt_next;
    logic [PKT_LEN_W-1:0]   r_beat_idx,  w_beat_idx_next;
    logic [63:0]            r_payload,   w_payload_next;
    logic [7:0]             r_gap_cnt,   w_gap_cnt_next;
    logic                   r_stop_pend, w_stop_pend_next;
    logic [127:0]           r_tdata,     w_tdata_next;
    logic                   r_tlast,     w_tlast_next;
    logic                   r_tvalid,    w_tvalid_next;
    logic                   r_busy,      w_busy_next;
    logic                   r_done,      w_done_next;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                   w_accept;
    logic [63:0]            w_payload_adv;
    logic [15:0]            w_pkt_cnt_inc;
    logic [PKT_LEN_W-1:0]   w_beat_inc;
    logic [PKT_LEN_W-1:0]   w_start_last_idx;
    logic                   w_stop_any;
    logic                   w_run_end;

`ifdef AXIS_TEST_GEN_PRBS_EN
    localparam logic [63:0] PAYLOAD_SEED = 64'h1;
    assign w_payload_adv = {r_payload[62:0],
                            r_payload[63] ^ r_payload[62] ^ r_payload[60] ^ r_payload[59]};
`else
    localparam logic [63:0] PAYLOAD_SEED = 64'h0;
    assign w_payload_adv = r_payload + 64'd1;
`endif

    assign w_accept         = r_tvalid & i_m_axis_link_tready;
    assign w_pkt_cnt_inc    = r_pkt_cnt + 16'd1;
    assign w_beat_inc       = r_beat_idx + PKT_LEN_W'(1);
    // A zero length is folded to one beat at latch time, so tlast is a
    // simple equality compare everywhere else.
    assign w_start_last_idx = (i_pkt_len == '0) ? '0 : (i_pkt_len - PKT_LEN_W'(1));
    // A stop arriving in the very cycle of the final beat is honoured too.
    assign w_stop_any       = r_stop_pend | i_stop;
    assign w_run_end        = w_stop_any |
                              ((r_pkt_num != 16'd0) && (w_pkt_cnt_inc == r_pkt_num));

    function automatic logic [127:0] pack_beat(
        input logic [15:0]          pkt,
        input logic [PKT_LEN_W-1:0] beat,
        input logic [63:0]          pay
    );
        return {16'd0, pkt, 32'(beat), pay};
    endfunction

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_last_idx_next  = r_last_idx;
        w_gap_len_next   = r_gap_len;
        w_pkt_num_next   = r_pkt_num;
        w_pkt_cnt_next   = r_pkt_cnt;
        w_beat_idx_next  = r_beat_idx;
        w_payload_next   = r_payload;
        w_gap_cnt_next   = r_gap_cnt;
        w_stop_pend_next = r_stop_pend;
        w_tdata_next     = r_tdata;
        w_tlast_next     = r_tlast;
        w_tvalid_next    = r_tvalid;
        w_busy_next      = r_busy;
        w_done_next      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tvalid_next    = 1'b0;
                w_busy_next      = 1'b0;
                w_stop_pend_next = 1'b0;   // stop alone, or alongside start, is dropped
                if (i_start) begin
                    w_last_idx_next = w_start_last_idx;
                    w_gap_len_next  = i_gap_len;
                    w_pkt_num_next  = i_pkt_num;
                    w_pkt_cnt_next  = 16'd0;
                    w_beat_idx_next = '0;
                    w_payload_next  = PAYLOAD_SEED;
                    w_tdata_next    = pack_beat(16'd0, '0, PAYLOAD_SEED);
                    w_tlast_next    = (w_start_last_idx == '0);
                    w_tvalid_next   = 1'b1;
                    w_busy_next     = 1'b1;
                    w_state_next    = ST_SEND;
                end
            end

            ST_SEND: begin
                if (i_stop) begin
                    w_stop_pend_next = 1'b1;
                end
                if (w_accept) begin
                    w_payload_next = w_payload_adv;
                    if (!r_tlast) begin
                        w_beat_idx_next = w_beat_inc;
                        w_tdata_next    = pack_beat(r_pkt_cnt, w_beat_inc, w_payload_adv);
                        w_tlast_next    = (w_beat_inc == r_last_idx);
                    end else begin
                        w_pkt_cnt_next  = w_pkt_cnt_inc;
                        w_beat_idx_next = '0;
                        if (w_run_end) begin
                            w_tvalid_next    = 1'b0;
                            w_tlast_next     = 1'b0;
                            w_busy_next      = 1'b0;
                            w_done_next      = 1'b1;
                            w_stop_pend_next = 1'b0;
                            w_state_next     = ST_IDLE;
                        end else if (r_gap_len == 8'd0) begin
                            // Back-to-back packets: no bubble between them.
                            w_tdata_next = pack_beat(w_pkt_cnt_inc, '0, w_payload_adv);
                            w_tlast_next = (r_last_idx == '0);
                        end else begin
                            w_tvalid_next  = 1'b0;
                            w_tlast_next   = 1'b0;
                            w_gap_cnt_next = r_gap_len;
                            w_state_next   = ST_GAP;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (w_stop_any) begin
                    w_busy_next      = 1'b0;
                    w_done_next      = 1'b1;
                    w_stop_pend_next = 1'b0;
                    w_state_next     = ST_IDLE;
                end else if (r_gap_cnt <= 8'd1) begin
                    // The count is loaded with gap_len on entry, so leaving on
                    // the count of one gives exactly gap_len idle cycles.
                    w_tdata_next  = pack_beat(r_pkt_cnt, '0, r_payload);
                    w_tlast_next  = (r_last_idx == '0);
                    w_tvalid_next = 1'b1;
                    w_state_next  = ST_SEND;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - 8'd1;
                end
            end

            default: begin
                w_tvalid_next = 1'b0;
                w_busy_next   = 1'b0;
                w_state_next  = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_link_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_last_idx  <= '0;
            r_gap_len   <= 8'd0;
            r_pkt_num   <= 16'd0;
            r_pkt_cnt   <= 16'd0;
            r_beat_idx  <= '0;
            r_payload   <= PAYLOAD_SEED;
            r_gap_cnt   <= 8'd0;
            r_stop_pend <= 1'b0;
            r_tdata     <= 128'd0;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_last_idx  <= w_last_idx_next;
            r_gap_len   <= w_gap_len_next;
            r_pkt_num   <= w_pkt_num_next;
            r_pkt_cnt   <= w_pkt_cnt_next;
            r_beat_idx  <= w_beat_idx_next;
            r_payload   <= w_payload_next;
            r_gap_cnt   <= w_gap_cnt_next;
            r_stop_pend <= w_stop_pend_next;
            r_tdata     <= w_tdata_next;
            r_tlast     <= w_tlast_next;
            r_tvalid    <= w_tvalid_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    assign o_m_axis_link_tdata  = r_tdata;
    assign o_m_axis_link_tlast  = r_tlast;
    assign o_m_axis_link_tvalid = r_tvalid;
    assign o_busy               = r_busy;
    assign o_done               = r_done;
    assign o_pkt_cnt            = r_pkt_cnt;

endmodule

// File: tb/tb_axis_test_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_test_gen
//
// Directed bench for axis_test_gen. Inputs are driven 1 time unit after the
// rising edge; outputs are sampled at the same point, i.e. after the edge has
// settled. Expected beat contents are computed from the packet/beat/payload
// indices the bench itself tracks.
// -----------------------------------------------------------------------------
module tb_axis_test_gen;

    localparam int PKT_LEN_W = 16;

    logic                 clk     = 1'b0;
    logic                 rst     = 1'b1;
    logic                 start   = 1'b0;
    logic                 stop    = 1'b0;
    logic [PKT_LEN_W-1:0] pkt_len = '0;
    logic [7:0]           gap_len = 8'd0;
    logic [15:0]          pkt_num = 16'd0;
    logic                 tready  = 1'b1;
    logic [127:0]         tdata;
    logic                 tlast;
    logic                 tvalid;
    logic                 busy;
    logic                 done;
    logic [15:0]          pkt_cnt;

    int n_vec = 0;
    int n_err = 0;

    axis_test_gen #(.PKT_LEN_W(PKT_LEN_W)) dut (
        .i_link_clk           (clk),
        .i_rst                (rst),
        .i_start              (start),
        .i_stop               (stop),
        .i_pkt_len            (pkt_len),
        .i_gap_len            (gap_len),
        .i_pkt_num            (pkt_num),
        .o_m_axis_link_tdata  (tdata),
        .o_m_axis_link_tlast  (tlast),
        .o_m_axis_link_tvalid (tvalid),
        .i_m_axis_link_tready (tready),
        .o_busy               (busy),
        .o_done               (done),
        .o_pkt_cnt            (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] exp_payload(input int k);
        logic [63:0] s;
`ifdef AXIS_TEST_GEN_PRBS_EN
        s = 64'h1;
        for (int i = 0; i < k; i++) s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
`else
        s = 64'(k);
`endif
        return s;
    endfunction

    function automatic logic [127:0] exp_beat(input int len_eff, input int k);
        int pkt;
        int beat;
        pkt  = k / len_eff;
        beat = k % len_eff;
        return {pkt[31:0], beat[31:0], exp_payload(k)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 unit after an edge; returns at the sample point of the first beat.
    task automatic launch(input int len, input int gap, input int num, input bit with_stop);
        pkt_len = PKT_LEN_W'(len);
        gap_len = 8'(gap);
        pkt_num = 16'(num);
        start   = 1'b1;
        stop    = with_stop;
        tick();
        start   = 1'b0;
        stop    = 1'b0;
    endtask

    // Consumes nbeats beats, checking content, hold-while-stalled and the
    // end-of-run status. With bp set, tready follows 1,0,0,1 repeatedly.
    task automatic run_collect(input string tag, input int len_eff, input int nbeats,
                               input bit bp, input int stop_at, input int exp_cnt);
        int           k = 0;
        int           cyc = 0;
        bit           prev_stall = 1'b0;
        bit           rdy;
        logic [127:0] prev_data = '0;
        int           bp_pat[4] = '{1, 0, 0, 1};
        while (k < nbeats && cyc < 400) begin
            stop = 1'b0;
            if (prev_stall) begin
                chk({tag, "_hold_valid"}, tvalid, 1'b1);
                chk({tag, "_hold_data"}, tdata, prev_data);
            end
            if (tvalid) begin
                chk({tag, "_data"}, tdata, exp_beat(len_eff, k));
                chk({tag, "_last"}, tlast, ((k % len_eff) == len_eff - 1));
                chk({tag, "_busy"}, busy, 1'b1);
                if (k == stop_at) stop = 1'b1;
            end
            rdy        = bp ? (bp_pat[cyc % 4] != 0) : 1'b1;
            tready     = rdy;
            prev_stall = tvalid && !rdy;
            prev_data  = tdata;
            if (tvalid && rdy) k++;
            cyc++;
            tick();
        end
        stop   = 1'b0;
        tready = 1'b1;
        if (k < nbeats) chk({tag, "_timeout"}, 128'(k), 128'(nbeats));
        chk({tag, "_done"},    done,    1'b1);
        chk({tag, "_busy_end"}, busy,   1'b0);
        chk({tag, "_valid_end"}, tvalid, 1'b0);
        chk({tag, "_pkt_cnt"}, pkt_cnt, 16'(exp_cnt));
    endtask

    initial begin
        int vpat[8] = '{1, 1, 1, 0, 0, 1, 1, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_tdata", tdata, 128'd0);
        chk("rst_tlast", tlast, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pkt_cnt", pkt_cnt, 16'd0);
        rst = 1'b0;
        tick();

        // T1: 2 x 4 beats back to back, one beat per cycle
        launch(4, 0, 2, 1'b0);
        chk("t1_busy_first", busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("t1_valid", tvalid, 1'b1);
            chk("t1_data", tdata, exp_beat(4, i));
            chk("t1_last", tlast, (i % 4) == 3);
`ifndef AXIS_TEST_GEN_PRBS_EN
            if (i == 5) chk("t1_beat5", tdata, {32'd1, 32'd1, 64'd5});
`endif
            tick();
        end
        chk("t1_done", done, 1'b1);
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_valid_end", tvalid, 1'b0);
        chk("t1_pkt_cnt", pkt_cnt, 16'd2);
        tick();
        chk("t1_done_pulse", done, 1'b0);

        // T2: 3-beat packets with a 2-cycle gap
        launch(3, 2, 2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("t2_valid_pat", tvalid, vpat[i] != 0);
            if (i == 5) chk("t2_pkt1_beat0", tdata, exp_beat(3, 3));
            tick();
        end
        chk("t2_done", done, 1'b1);
        tick();

        // T3: backpressure with a gap
        launch(4, 1, 2, 1'b0);
        run_collect("t3", 4, 8, 1'b1, -1, 2);
        tick();

        // T4: unlimited run, stop on 2nd beat of the 3rd packet
        launch(5, 0, 0, 1'b0);
        run_collect("t4", 5, 15, 1'b0, 11, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_no_more", tvalid, 1'b0);
        end
        chk("t4_pkt_cnt_hold", pkt_cnt, 16'd3);

        // T5: zero length packets; stop together with start is dropped
        launch(0, 0, 3, 1'b1);
        run_collect("t5", 1, 3, 1'b0, -1, 3);
        tick();

        // Stop while idle does nothing
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk("idle_stop_busy", busy, 1'b0);
        chk("idle_stop_valid", tvalid, 1'b0);

        // T6: reset mid-run, then restart from packet 0 beat 0
        launch(2, 0, 0, 1'b0);
        repeat (3) tick();
        chk("t6_pre_cnt", pkt_cnt, 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", tvalid, 1'b0);
        chk("t6_rst_data", tdata, 128'd0);
        chk("t6_rst_last", tlast, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_cnt", pkt_cnt, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        launch(2, 0, 1, 1'b0);
        run_collect("t6", 2, 2, 1'b0, -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_test_gen.md
# axis_test_gen

AXI-Stream test-pattern source for the 128-bit link datapath of the facc_5g test infrastructure. On a start pulse it emits a programmed number of fixed-length packets, separated by a programmable idle gap, with self-describing beat contents. A sink can check each beat without side information. The block drives the same link stream that the DMA-side test sink consumes, so a loopback bench or board bring-up runs without a DMA.

## Interface
- PKT_LEN_W, 16, width of the pkt_len input (beats per packet)
- link_clk  in  1  stream clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches config and begins a run (ignored while busy)
- stop  in  1  one-cycle pulse; finish the current packet, then end the run
- pkt_len  in  PKT_LEN_W  beats per packet; 0 is treated as 1
- gap_len  in  8  idle cycles (tvalid=0) between packets
- pkt_num  in  16  packets per run; 0 = unlimited (runs until stop)
- m_axis_link_tdata  out  128  beat data
- m_axis_link_tlast  out  1  last beat of packet
- m_axis_link_tvalid  out  1  beat valid
- m_axis_link_tready  in  1  sink ready
- busy  out  1  high from the cycle after start until the cycle done pulses
- done  out  1  one-cycle pulse when a run ends
- pkt_cnt  out  16  packets completed in the current or last run; wraps at 16'hFFFF

## Operation
- Handshake: a beat transfers when tvalid & tready. All stream outputs are registered. Once tvalid rises, tdata and tlast hold until the beat is accepted. tvalid never drops without acceptance. tvalid does not depend combinationally on tready.
- FSM states: IDLE, SEND, GAP.
- IDLE: tvalid=0, busy=0. On start, latch pkt_len, gap_len and pkt_num, clear pkt_cnt and the beat counters, then go to SEND.
- SEND: present the beat. On an accepted beat with tlast=0, advance to the next beat. On an accepted beat with tlast=1:
  - increment pkt_cnt;
  - if a stop is pending, or pkt_num≠0 and the new pkt_cnt==pkt_num, go to IDLE and pulse done;
  - otherwise, if gap_len==0, stay in SEND with the next packet's first beat;
  - otherwise go to GAP.
- GAP: tvalid=0 for exactly gap_len cycles, then go to SEND. A stop received in GAP ends the run: go to IDLE and pulse done the next cycle. No further packet is started.
- stop is latched as pending in any busy state. Packets are never truncated.
- start while busy, or stop while IDLE: no effect. start and stop in the same IDLE cycle: start wins and stop is dropped.
- Beat format:
  - tdata[127:96] = packet index (pkt_cnt value at packet start, zero-extended);
  - tdata[95:64] = beat index within the packet, starting at 0, zero-extended;
  - tdata[63:0] = payload word (see Configuration);
  - tlast=1 when beat index == effective pkt_len−1.
- Payload counter: cleared on start; increments by 1 per accepted beat across packets; wraps modulo 2^64.
- Reset mid-run: all outputs return to their reset values immediately. The FSM goes to IDLE. Any stop pending is discarded.

## Timing
- Reset values: tdata=0, tlast=0, tvalid=0, busy=0, done=0, pkt_cnt=0.
- start at cycle N: busy=1 and tvalid=1 with the first beat at N+1.
- Sustained throughput: one beat per cycle while tready=1, including across packets when gap_len=0.
- Last beat of a packet accepted at cycle M, with gap_len=G>0: tvalid=0 for cycles M+1..M+G, and the next first beat is valid at M+G+1.
- Final beat accepted at cycle M: done=1 and busy=0 at M+1, with tvalid=0.

## Configuration
- AXIS_TEST_GEN_PRBS_EN defined: tdata[63:0] is a 64-bit Fibonacci LFSR.
  - Next value = {s[62:0], s[63]^s[62]^s[60]^s[59]}.
  - Seeded to 64'h1 on reset and on start.
  - Advances once per accepted beat, so the first beat carries 64'h1.
- Not defined: tdata[63:0] is the incrementing payload counter, and the first beat carries 0. LFSR logic is not synthesized.

## Test plan
- Macro undefined; pkt_len=4, gap_len=0, pkt_num=2, tready=1, start at cycle 10 -> 8 consecutive valid beats at cycles 11-18. tlast at 14 and 18. Beat 5 tdata = {32'd1, 32'd1, 64'd5}. done=1 at 19. pkt_cnt=2.
- pkt_len=3, gap_len=2, pkt_num=2, tready=1 -> tvalid pattern 1,1,1,0,0,1,1,1, then done.
- Backpressure: tready toggles 1,0,0,1 repeatedly -> tdata/tlast stable while stalled. No beat lost or duplicated. Beat indices are contiguous.
- pkt_num=0, pkt_len=5, with stop asserted on the 2nd beat of packet 3 -> packet 3 completes all 5 beats with tlast, then done. pkt_cnt=3. No 4th packet.
- pkt_len=0 -> every beat has tlast=1 and beat index 0. Separately, rst asserted mid-packet -> outputs go to 0 immediately. A subsequent start restarts at packet 0, beat 0.
- AXIS_TEST_GEN_PRBS_EN defined; pkt_len=2, pkt_num=1 -> tdata[63:0] = 64'h1 on beat 0 and 64'h2 on beat 1.
